// File: rtl/sd_track_cache.sv
// Track-buffer cache between a 1541/1571 drive core and SD block storage.
// Optional TRACK_CACHE_DIRTY_EN skips write-back of unmodified tracks.
module sd_track_cache #(
  parameter int MAX_TRACKS = 40,
  parameter int BLOCKS     = 16,
  parameter int DUAL_SIDE  = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic [31:0]                 sd_lba,
  output logic                        sd_rd,
  output logic                        sd_wr,
  input  logic                        sd_ack,
  input  logic [8:0]                  sd_buff_addr,
  input  logic [7:0]                  sd_buff_dout,
  output logic [7:0]                  sd_buff_din,
  input  logic                        sd_buff_wr,
  input  logic                        save_track,
  input  logic                        change,
  input  logic                        mount,
  input  logic                        img_ds,
  input  logic [5:0]                  track,
  input  logic                        side,
  input  logic                        drv_we,
  output logic [$clog2(BLOCKS)+8:0]   ram_addr,
  output logic [7:0]                  ram_di,
  input  logic [7:0]                  ram_do,
  output logic                        ram_we,
  output logic                        sector_offset,
  output logic                        busy,
  output logic                        dirty
);

  localparam int            BW   = $clog2(BLOCKS);
  localparam logic [BW-1:0] LAST = BW'(BLOCKS - 1);
  localparam logic [BW-1:0] ONE  = BW'(1);
  localparam logic [5:0]    MAXT = 6'(MAX_TRACKS);
  localparam logic [5:0]    INV  = 6'h3F;
  localparam logic          DS   = 1'(DUAL_SIDE != 0);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SAVE,
    SAVE_THEN_LOAD
  } state_t;

  // Zoned 1541 layout: 21/19/18/17 sectors per track, side 1 after 683.
  function automatic logic [10:0] start_sec(input logic [5:0] t,
                                            input logic       s);
    logic [10:0] tt;
    logic [10:0] r;
    tt = {5'd0, t};
    if (tt <= 11'd17)
      r = (tt - 11'd1) * 11'd21;
    else if (tt <= 11'd24)
      r = 11'd357 + (tt - 11'd18) * 11'd19;
    else if (tt <= 11'd30)
      r = 11'd490 + (tt - 11'd25) * 11'd18;
    else
      r = 11'd598 + (tt - 11'd31) * 11'd17;
    if (s)
      r = r + 11'd683;
    return r;
  endfunction

  state_t        state_q, state_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   lba_q, lba_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          off_q, off_d;
  logic          ready_q, ready_d;
  logic          dirty_q, dirty_d;
  logic [5:0]    cur_trk_q, cur_trk_d, pend_trk_q, pend_trk_d;
  logic          cur_side_q, cur_side_d, pend_side_q, pend_side_d;
  logic          change_q, ack_q;

  logic [5:0]  trk_c;
  logic        side_e;
  logic [10:0] s_new, s_cur, s_pend;
  logic        chg_rise, chg_fall, ack_fall;
  logic        load_ok, save_ok, save_gate, dirty_set;

  assign trk_c  = (track == 6'd0) ? 6'd1 :
                  (track > MAXT)  ? MAXT : track;
  assign side_e = side & img_ds & DS;
  assign s_new  = start_sec(trk_c, side_e);
  assign s_cur  = start_sec(cur_trk_q, cur_side_q);
  assign s_pend = start_sec(pend_trk_q, pend_side_q);

  assign chg_rise = ~change_q & change;
  assign chg_fall = change_q & ~change;
  assign ack_fall = ack_q & ~sd_ack;

`ifdef TRACK_CACHE_DIRTY_EN
  assign save_gate = dirty_q;
  assign dirty_set = drv_we;
`else
  logic unused_drv_we;
  assign unused_drv_we = drv_we;
  assign save_gate     = 1'b1;
  assign dirty_set     = 1'b0;
`endif

  assign load_ok = ({trk_c, side_e} != {cur_trk_q, cur_side_q}) | chg_fall;
  assign save_ok = save_track & (cur_trk_q != INV) & save_gate;

  assign ram_addr      = {blk_q, sd_buff_addr};
  assign ram_di        = sd_buff_dout;
  assign sd_buff_din   = ram_do;
  assign ram_we        = sd_buff_wr;
  assign sd_lba        = lba_q;
  assign sd_rd         = rd_q;
  assign sd_wr         = wr_q;
  assign sector_offset = off_q;
  assign busy          = (state_q != IDLE);
  assign dirty         = dirty_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      lba_q       <= '0;
      blk_q       <= '0;
      off_q       <= 1'b0;
      ready_q     <= 1'b0;
      dirty_q     <= 1'b0;
      cur_trk_q   <= INV;
      cur_side_q  <= 1'b0;
      pend_trk_q  <= INV;
      pend_side_q <= 1'b0;
      change_q    <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      lba_q       <= lba_d;
      blk_q       <= blk_d;
      off_q       <= off_d;
      ready_q     <= ready_d;
      dirty_q     <= dirty_d;
      cur_trk_q   <= cur_trk_d;
      cur_side_q  <= cur_side_d;
      pend_trk_q  <= pend_trk_d;
      pend_side_q <= pend_side_d;
      change_q    <= change;
      ack_q       <= sd_ack;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    lba_d       = lba_q;
    blk_d       = blk_q;
    off_d       = off_q;
    ready_d     = ready_q;
    dirty_d     = dirty_q;
    cur_trk_d   = cur_trk_q;
    cur_side_d  = cur_side_q;
    pend_trk_d  = pend_trk_q;
    pend_side_d = pend_side_q;

    if (chg_rise)
      ready_d = mount;
    if (sd_ack) begin
      rd_d = 1'b0;
      wr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (dirty_set)
          dirty_d = 1'b1;
        if (ready_q && save_ok) begin
          state_d     = load_ok ? SAVE_THEN_LOAD : SAVE;
          wr_d        = 1'b1;
          blk_d       = '0;
          lba_d       = {22'd0, s_cur[10:1]};
          off_d       = s_cur[0];
          pend_trk_d  = trk_c;
          pend_side_d = side_e;
        end else if (ready_q && load_ok) begin
          state_d    = LOAD;
          rd_d       = 1'b1;
          blk_d      = '0;
          lba_d      = {22'd0, s_new[10:1]};
          off_d      = s_new[0];
          cur_trk_d  = trk_c;
          cur_side_d = side_e;
        end
      end
      default: begin
        if (ack_fall) begin
          if (blk_q != LAST) begin
            blk_d = blk_q + ONE;
            lba_d = lba_q + 32'd1;
            if (state_q == LOAD)
              rd_d = 1'b1;
            else
              wr_d = 1'b1;
          end else begin
            dirty_d = 1'b0;
            state_d = IDLE;
            // Save-to-load handoff keeps busy high across the phase change.
            if (state_q == SAVE_THEN_LOAD && ready_q) begin
              state_d    = LOAD;
              rd_d       = 1'b1;
              blk_d      = '0;
              lba_d      = {22'd0, s_pend[10:1]};
              off_d      = s_pend[0];
              cur_trk_d  = pend_trk_q;
              cur_side_d = pend_side_q;
            end
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_sd_track_cache.sv
// Directed bench for sd_track_cache with a simple SD-card ack responder.
// Covers loads, zone bases, side 1, save/load handoff, reset and dirty mode.
module tb_sd_track_cache;

`ifdef TRACK_CACHE_DIRTY_EN
  localparam bit DEN = 1'b1;
`else
  localparam bit DEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;
  logic        save_track, change, mount, img_ds;
  logic [5:0]  track;
  logic        side, drv_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_di, ram_do;
  logic        ram_we, sector_offset, busy, dirty;

  int checks = 0;
  int errors = 0;
  logic [32:0] log_q[$];
  int ack_cnt = 0;

  sd_track_cache #(
    .MAX_TRACKS(40),
    .BLOCKS(16),
    .DUAL_SIDE(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
    .save_track(save_track), .change(change), .mount(mount),
    .img_ds(img_ds), .track(track), .side(side), .drv_we(drv_we),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
    .ram_we(ram_we), .sector_offset(sector_offset),
    .busy(busy), .dirty(dirty)
  );

  always #5 clk = ~clk;

  // SD responder: log each request, ack for two cycles, then release.
  always @(posedge clk) begin
    if (sd_ack) begin
      ack_cnt = ack_cnt + 1;
      if (ack_cnt >= 2)
        sd_ack <= 1'b0;
    end else if (sd_rd || sd_wr) begin
      log_q.push_back({sd_wr, sd_lba});
      ack_cnt = 0;
      sd_ack <= 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge clk);
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_seq(input string tag, input int idx0, input int n,
                         input bit wr, input int lba0);
    for (int i = 0; i < n; i++) begin
      if (idx0 + i < log_q.size())
        chk(tag, 64'(log_q[idx0 + i]), 64'({wr, 32'(lba0 + i)}));
      else
        chk({tag, " missing"}, 64'(log_q.size()), 64'(idx0 + n));
    end
  endtask

  task automatic load_chk(input string tag, input logic [5:0] t,
                          input logic s, input logic ds,
                          input int lba0, input logic off);
    log_q.delete();
    track  = t;
    side   = s;
    img_ds = ds;
    wait_idle(tag);
    chk({tag, " count"}, 64'(log_q.size()), 64'd16);
    chk_seq(tag, 0, 16, 1'b0, lba0);
    chk({tag, " offset"}, 64'(sector_offset), 64'(off));
  endtask

  task automatic pulse_change();
    change = 1'b1;
    @(negedge clk);
    change = 1'b0;
  endtask

  initial begin
    int k;
    int lows;
    reset_n      = 1'b0;
    save_track   = 1'b0;
    change       = 1'b0;
    mount        = 1'b0;
    img_ds       = 1'b0;
    track        = 6'd0;
    side         = 1'b0;
    drv_we       = 1'b0;
    sd_buff_addr = 9'd0;
    sd_buff_dout = 8'd0;
    sd_buff_wr   = 1'b0;
    ram_do       = 8'd0;
    repeat (3) @(negedge clk);

    chk("rst sd_rd", 64'(sd_rd), 64'd0);
    chk("rst sd_wr", 64'(sd_wr), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst dirty", 64'(dirty), 64'd0);
    chk("rst offset", 64'(sector_offset), 64'd0);
    chk("rst lba", 64'(sd_lba), 64'd0);
    reset_n = 1'b1;

    sd_buff_addr = 9'h137;
    sd_buff_dout = 8'hA5;
    sd_buff_wr   = 1'b1;
    ram_do       = 8'h3C;
    #1;
    chk("ram_addr", 64'(ram_addr), 64'h137);
    chk("ram_di", 64'(ram_di), 64'hA5);
    chk("ram_we", 64'(ram_we), 64'd1);
    chk("sd_buff_din", 64'(sd_buff_din), 64'h3C);
    sd_buff_wr = 1'b0;
    @(negedge clk);

    track = 6'd18;
    repeat (10) @(negedge clk);
    chk("unmounted busy", 64'(busy), 64'd0);
    chk("unmounted traffic", 64'(log_q.size()), 64'd0);

    mount = 1'b1;
    pulse_change();
    k = 0;
    while (log_q.size() < 16 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("t18 busy at 16th", 64'(busy), 64'd1);
    wait_idle("t18");
    chk("t18 count", 64'(log_q.size()), 64'd16);
    chk_seq("t18 lba", 0, 16, 1'b0, 178);
    chk("t18 offset", 64'(sector_offset), 64'd1);

    load_chk("t25", 6'd25, 1'b0, 1'b0, 245, 1'b0);
    load_chk("t31", 6'd31, 1'b0, 1'b0, 299, 1'b0);
    load_chk("t0 clamp", 6'd0, 1'b0, 1'b0, 0, 1'b0);
    load_chk("t63 clamp", 6'd63, 1'b0, 1'b0, 375, 1'b1);
    load_chk("side1 t1", 6'd1, 1'b1, 1'b1, 341, 1'b1);
    load_chk("ss side1 t1", 6'd1, 1'b1, 1'b0, 0, 1'b0);

    drv_we = 1'b1;
    @(negedge clk);
    drv_we = 1'b0;
    @(negedge clk);
    chk("dirty after we", 64'(dirty), 64'(DEN));

    log_q.delete();
    save_track = 1'b1;
    track      = 6'd2;
    side       = 1'b0;
    @(negedge clk);
    save_track = 1'b0;
    k    = 0;
    lows = 0;
    while (log_q.size() < 32 && k < 4000) begin
      if (!busy)
        lows++;
      @(negedge clk);
      k++;
    end
    chk("stl busy held", 64'(lows), 64'd0);
    wait_idle("stl");
    chk("stl count", 64'(log_q.size()), 64'd32);
    chk_seq("stl save", 0, 16, 1'b1, 0);
    chk_seq("stl load", 16, 16, 1'b0, 10);
    chk("stl offset", 64'(sector_offset), 64'd1);
    chk("stl dirty", 64'(dirty), 64'd0);

    log_q.delete();
`ifdef TRACK_CACHE_DIRTY_EN
    save_track = 1'b1;
    @(negedge clk);
    save_track = 1'b0;
    repeat (20) @(negedge clk);
    chk("clean save traffic", 64'(log_q.size()), 64'd0);
    chk("clean save busy", 64'(busy), 64'd0);
    drv_we = 1'b1;
    @(negedge clk);
    drv_we = 1'b0;
    @(negedge clk);
    chk("dirty set", 64'(dirty), 64'd1);
    save_track = 1'b1;
    @(negedge clk);
    save_track = 1'b0;
    wait_idle("dirty save");
    chk("dirty save count", 64'(log_q.size()), 64'd16);
    chk_seq("dirty save", 0, 16, 1'b1, 10);
    chk("dirty cleared", 64'(dirty), 64'd0);
`else
    save_track = 1'b1;
    @(negedge clk);
    save_track = 1'b0;
    wait_idle("plain save");
    chk("plain save count", 64'(log_q.size()), 64'd16);
    chk_seq("plain save", 0, 16, 1'b1, 10);
    drv_we = 1'b1;
    @(negedge clk);
    drv_we = 1'b0;
    @(negedge clk);
    chk("dirty tied low", 64'(dirty), 64'd0);
`endif

    log_q.delete();
    track = 6'd18;
    k = 0;
    while (log_q.size() < 8 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("blk7 reached", 64'(log_q.size()), 64'd8);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst sd_rd", 64'(sd_rd), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst lba", 64'(sd_lba), 64'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    log_q.delete();
    pulse_change();
    wait_idle("reload");
    chk("reload count", 64'(log_q.size()), 64'd16);
    chk_seq("reload lba", 0, 16, 1'b0, 178);
    chk("reload offset", 64'(sector_offset), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
